seg_pipe_adder: RTL and testbench

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

---
 rtl/seg_pipe_adder_if.sv | 30 +++
 rtl/seg_pipe_adder.sv | 129 ++++++++++++
 tb/tb_seg_pipe_adder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pipe_adder_if.sv
// Operand/result handshake bundle for seg_pipe_adder.
// The master drives operands and out_ready; the slave (the adder) drives results.
interface seg_pipe_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         carry_in;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         carry_out;
  logic         flag_n;
  logic         flag_z;
  logic         flag_v;

  modport master (
    output in_valid, a, b, sub, carry_in, flush, out_ready,
    input  in_ready, out_valid, s, carry_out, flag_n, flag_z, flag_v
  );

  modport slave (
    input  in_valid, a, b, sub, carry_in, flush, out_ready,
    output in_ready, out_valid, s, carry_out, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/seg_pipe_adder.sv
// Carry-segmented pipelined adder/subtractor: SEG stages, each adding one N/SEG-bit slice.
// The whole pipe advances together and holds as one unit while the output is stalled.
module seg_pipe_adder #(
  parameter int N   = 32,
  parameter int SEG = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg_pipe_adder_if.slave    bus
);
  localparam int W = N / SEG;

  if ((SEG < 1) || ((N % SEG) != 0)) begin : g_bad_seg
    $error("seg_pipe_adder: N must be a positive multiple of SEG");
  end

  logic [N-1:0] w_be;
  logic         w_stall;
  logic         w_adv;

  assign w_be         = bus.sub ? ~bus.b : bus.b;
  assign w_stall      = bus.out_valid & ~bus.out_ready;
  assign w_adv        = ~w_stall;
  assign bus.in_ready = ~w_stall;

  // Stage k owns sum bits [DONE-1:0] and forwards only the operand bits above DONE.
  for (genvar k = 0; k < SEG; k++) begin : g_st
    localparam int DONE = (k + 1) * W;

    logic [W-1:0]    w_sa;
    logic [W-1:0]    w_sb;
    logic            w_ci;
    logic            w_vin;
    logic [W:0]      w_sum;
    logic [DONE-1:0] w_snext;
    logic            r_v;
    logic            r_c;
    logic [DONE-1:0] r_s;

    if (k == 0) begin : g_src
      assign w_sa    = bus.a[W-1:0];
      assign w_sb    = w_be[W-1:0];
      assign w_ci    = bus.carry_in;
      assign w_vin   = bus.in_valid;
    end else begin : g_src
      assign w_sa    = g_st[k-1].g_fwd.r_a[W-1:0];
      assign w_sb    = g_st[k-1].g_fwd.r_b[W-1:0];
      assign w_ci    = g_st[k-1].r_c;
      assign w_vin   = g_st[k-1].r_v;
    end

    assign w_sum = {1'b0, w_sa} + {1'b0, w_sb} + {{W{1'b0}}, w_ci};

    if (k == 0) begin : g_snext
      assign w_snext = w_sum[W-1:0];
    end else begin : g_snext
      assign w_snext = {w_sum[W-1:0], g_st[k-1].r_s};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else begin
        if (bus.flush) begin
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_v <= w_vin;
        end
        if (w_adv) begin
          r_c <= w_sum[W];
          r_s <= w_snext;
        end
      end
    end

    if (k < SEG - 1) begin : g_fwd
      logic [N-DONE-1:0] r_a;
      logic [N-DONE-1:0] r_b;
      logic [N-DONE-1:0] w_na;
      logic [N-DONE-1:0] w_nb;

      if (k == 0) begin : g_nsrc
        assign w_na = bus.a[N-1:DONE];
        assign w_nb = w_be[N-1:DONE];
      end else begin : g_nsrc
        assign w_na = g_st[k-1].g_fwd.r_a[N-k*W-1:W];
        assign w_nb = g_st[k-1].g_fwd.r_b[N-k*W-1:W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_na;
          r_b <= w_nb;
        end
      end
    end

    // The top slice carries a[N-1] and be[N-1], so overflow is resolved here.
    if (k == SEG - 1) begin : g_flags
      logic r_fn;
      logic r_fz;
      logic r_fv;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_fn <= 1'b0;
          r_fz <= 1'b0;
          r_fv <= 1'b0;
        end else if (w_adv) begin
          r_fn <= w_snext[DONE-1];
          r_fz <= (w_snext == '0);
          r_fv <= (w_sa[W-1] == w_sb[W-1]) && (w_snext[DONE-1] != w_sa[W-1]);
        end
      end
    end
  end

  assign bus.out_valid = g_st[SEG-1].r_v;
  assign bus.s         = g_st[SEG-1].r_s;
  assign bus.carry_out = g_st[SEG-1].r_c;
  assign bus.flag_n    = g_st[SEG-1].g_flags.r_fn;
  assign bus.flag_z    = g_st[SEG-1].g_flags.r_fz;
  assign bus.flag_v    = g_st[SEG-1].g_flags.r_fv;
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Bench for seg_pipe_adder: three builds (SEG=4,1,8 at N=8) share one stimulus stream
// and are each compared every cycle against a slot-level reference model.
module tb_seg_pipe_adder;
  localparam int N  = 8;
  localparam int NI = 3;
  localparam int S0 = 4;
  localparam int S1 = 1;
  localparam int S2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       d_in_valid = 1'b0;
  logic [7:0] d_a = 8'd0;
  logic [7:0] d_b = 8'd0;
  logic       d_sub = 1'b0;
  logic       d_cin = 1'b0;
  logic       d_flush = 1'b0;
  logic       d_out_ready = 1'b1;

  seg_pipe_adder_if #(.N(N)) bus0 ();
  seg_pipe_adder_if #(.N(N)) bus1 ();
  seg_pipe_adder_if #(.N(N)) bus2 ();

  seg_pipe_adder #(.N(N), .SEG(S0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seg_pipe_adder #(.N(N), .SEG(S1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seg_pipe_adder #(.N(N), .SEG(S2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.in_valid = d_in_valid;  assign bus1.in_valid = d_in_valid;  assign bus2.in_valid = d_in_valid;
  assign bus0.a = d_a;                assign bus1.a = d_a;                assign bus2.a = d_a;
  assign bus0.b = d_b;                assign bus1.b = d_b;                assign bus2.b = d_b;
  assign bus0.sub = d_sub;            assign bus1.sub = d_sub;            assign bus2.sub = d_sub;
  assign bus0.carry_in = d_cin;       assign bus1.carry_in = d_cin;       assign bus2.carry_in = d_cin;
  assign bus0.flush = d_flush;        assign bus1.flush = d_flush;        assign bus2.flush = d_flush;
  assign bus0.out_ready = d_out_ready; assign bus1.out_ready = d_out_ready; assign bus2.out_ready = d_out_ready;

  logic        o_v   [NI];
  logic        o_rdy [NI];
  logic [11:0] o_d   [NI];
  assign o_v[0] = bus0.out_valid;  assign o_rdy[0] = bus0.in_ready;
  assign o_v[1] = bus1.out_valid;  assign o_rdy[1] = bus1.in_ready;
  assign o_v[2] = bus2.out_valid;  assign o_rdy[2] = bus2.in_ready;
  assign o_d[0] = {bus0.carry_out, bus0.flag_n, bus0.flag_z, bus0.flag_v, bus0.s};
  assign o_d[1] = {bus1.carry_out, bus1.flag_n, bus1.flag_z, bus1.flag_v, bus1.s};
  assign o_d[2] = {bus2.carry_out, bus2.flag_n, bus2.flag_z, bus2.flag_v, bus2.s};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected result packed as {C, N, Z, V, s}, from whole-word arithmetic.
  function automatic logic [11:0] ref_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic sub, input logic cin);
    logic [7:0] be;
    logic [8:0] t;
    be = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {8'd0, cin};
    return {t[8], t[7], (t[7:0] == 8'd0), ((a[7] == be[7]) && (t[7] != a[7])), t[7:0]};
  endfunction

  // Reference: SEG slots per build that shift together unless the last one is held.
  int          segs [NI] = '{S0, S1, S2};
  bit          m_v  [NI][8];
  logic [11:0] m_d  [NI][8];
  bit          m_acc[NI];
  int          rx   [NI] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 1'b0;
      if (rst) begin
        for (int j = 0; j < 8; j++) begin
          m_v[i][j] = 1'b0;
          m_d[i][j] = 12'd0;
        end
      end else if (d_flush) begin
        for (int j = 0; j < 8; j++) m_v[i][j] = 1'b0;
      end else if (!(m_v[i][segs[i]-1] && !d_out_ready)) begin
        for (int j = segs[i] - 1; j > 0; j--) begin
          m_v[i][j] = m_v[i][j-1];
          m_d[i][j] = m_d[i][j-1];
        end
        m_v[i][0] = d_in_valid;
        m_d[i][0] = ref_calc(d_a, d_b, d_sub, d_cin);
        m_acc[i]  = d_in_valid;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        chk($sformatf("i%0d_rst_valid", i), o_v[i], 0);
        chk($sformatf("i%0d_rst_ready", i), o_rdy[i], 1);
        chk($sformatf("i%0d_rst_data", i), o_d[i], 0);
      end else begin
        chk($sformatf("i%0d_out_valid", i), o_v[i], m_v[i][segs[i]-1]);
        chk($sformatf("i%0d_in_ready", i), o_rdy[i], !(m_v[i][segs[i]-1] && !d_out_ready));
        if (m_v[i][segs[i]-1]) begin
          chk($sformatf("i%0d_result", i), o_d[i], m_d[i][segs[i]-1]);
          if (d_out_ready) rx[i]++;
        end
      end
    end
  end

  task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin);
    d_a = a; d_b = b; d_sub = sub; d_cin = cin; d_in_valid = 1'b1;
  endtask

  task automatic set_rand_op();
    set_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Entered and left just after a rising edge; the op is accepted on the next edge.
  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic cin, input logic [11:0] exp, input string nm);
    chk({nm, "_model"}, ref_calc(a, b, sub, cin), exp);
    set_op(a, b, sub, cin);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_seg1_valid"}, o_v[1], 1);
    chk({nm, "_seg1_data"}, o_d[1], exp);
    repeat (S0 - 1) @(posedge clk);
    @(negedge clk);
    chk({nm, "_seg4_valid"}, o_v[0], 1);
    chk({nm, "_seg4_data"}, o_d[0], exp);
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    int idx = 0;
    int stall_left = -1;
    int rx0 = rx[0];
    logic [11:0] held = 12'd0;
    set_rand_op();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (m_acc[0]) begin
        idx++;
        if (idx < 6) set_rand_op();
        else d_in_valid = 1'b0;
      end
      if (stall_left < 0 && o_v[0]) begin
        stall_left  = 3;
        d_out_ready = 1'b0;
        held        = o_d[0];
      end else if (stall_left > 0) begin
        chk("bp_in_ready_low", o_rdy[0], 0);
        chk("bp_s_held", o_d[0], held);
        stall_left--;
        if (stall_left == 0) d_out_ready = 1'b1;
      end
      if (idx >= 6 && (rx[0] - rx0) >= 6) break;
    end
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    chk("bp_stall_seen", (stall_left == 0), 1);
    chk("bp_result_count", rx[0] - rx0, 6);
  endtask

  task automatic flush_test();
    repeat (3) begin
      set_rand_op();
      @(posedge clk); #1;
    end
    set_rand_op();
    d_flush = 1'b1;
    @(posedge clk); #1;
    d_flush    = 1'b0;
    d_in_valid = 1'b0;
    chk("flush_in_ready_after", o_rdy[0], 1);
    repeat (S0) begin
      @(negedge clk);
      chk("flush_no_out_valid", o_v[0], 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic async_rst_test();
    repeat (4) begin
      set_rand_op();
      @(posedge clk); #1;
    end
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
    #1;
    chk("arst_pre_valid", o_v[0], 1);
    chk("arst_pre_stalled", o_rdy[0], 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", o_v[0], 0);
    chk("arst_in_ready", o_rdy[0], 1);
    chk("arst_data_zero", o_d[0], 0);
    chk("arst_seg8_valid", o_v[2], 0);
    @(posedge clk); #1;
    rst         = 1'b0;
    d_out_ready = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue1(8'hFF, 8'h01, 1'b0, 1'b0, 12'hA00, "wrap_zero");
    issue1(8'h7F, 8'h01, 1'b0, 1'b0, 12'h580, "pos_ovf");
    issue1(8'h05, 8'h07, 1'b1, 1'b1, 12'h4FE, "sub_neg");
    issue1(8'h80, 8'h01, 1'b1, 1'b1, 12'h97F, "sub_ovf");

    backpressure();
    repeat (10) @(posedge clk);
    #1;
    flush_test();
    async_rst_test();
    issue1(8'h80, 8'h01, 1'b1, 1'b1, 12'h97F, "post_rst");

    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(3) != 0) set_rand_op();
      else d_in_valid = 1'b0;
      d_out_ready = ($urandom_range(4) != 0);
      d_flush     = ($urandom_range(49) == 0);
      @(posedge clk); #1;
    end
    d_in_valid  = 1'b0;
    d_flush     = 1'b0;
    d_out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
